// File: rtl/conv_result_packer_if.sv
`default_nettype none
// ============================================================================
// conv_result_packer_if : tile input / SRAM write / status bundle
// Rev 1.0
// ============================================================================
interface conv_result_packer_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic [3:0]        in_tile;
   logic              in_ready;
   logic              flush;
   logic [ADDR_W-1:0] dut_sram_write_address;
   logic [15:0]       dut_sram_write_data;
   logic              dut_sram_write_enable;
   logic              busy;
   logic              done;
   logic              wrap;

   modport slave (
      input  start, base_addr, in_valid, in_tile, flush,
      output in_ready, dut_sram_write_address, dut_sram_write_data,
             dut_sram_write_enable, busy, done, wrap
   );

   modport master (
      output start, base_addr, in_valid, in_tile, flush,
      input  in_ready, dut_sram_write_address, dut_sram_write_data,
             dut_sram_write_enable, busy, done, wrap
   );
endinterface
`default_nettype wire

// File: rtl/conv_result_packer.sv
`default_nettype none
// ============================================================================
// conv_result_packer : packs four 2x2 result tiles per 16-bit SRAM word
// Rev 1.0
// ============================================================================
module conv_result_packer #(
   parameter int ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  reset_b,
   conv_result_packer_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       word_q, word_d;
   logic [2:0]        count_q, count_d;
   logic              wrap_q, wrap_d;
   logic              flush_pend_q, flush_pend_d;

   always_ff @(posedge clk) begin
      if (reset_b) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         word_q       <= '0;
         count_q      <= '0;
         wrap_q       <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         count_q      <= count_d;
         wrap_q       <= wrap_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      word_d       = word_q;
      count_d      = count_q;
      wrap_d       = wrap_q;
      flush_pend_d = flush_pend_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_COLLECT;
               addr_d       = bus.base_addr;
               word_d       = '0;
               count_d      = '0;
               wrap_d       = 1'b0;
               flush_pend_d = 1'b0;
            end
         end
         S_COLLECT: begin
            if (bus.in_valid) begin
               word_d[{count_q[1:0], 2'b00} +: 4] = bus.in_tile;
               count_d                            = count_q + 3'd1;
            end
            // A same-cycle tile is counted before the flush decision
            if (count_d == 3'd4) begin
               state_d      = S_WRITE;
               flush_pend_d = bus.flush;
            end else if (bus.flush) begin
               if (count_d != 3'd0) begin
                  state_d      = S_WRITE;
                  flush_pend_d = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WRITE: begin
            addr_d       = addr_q + 1'b1;
            word_d       = '0;
            count_d      = '0;
            flush_pend_d = 1'b0;
            if (&addr_q) begin
               wrap_d = 1'b1;
            end
            state_d = (flush_pend_q || bus.flush) ? S_DONE : S_COLLECT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready               = (state_q == S_COLLECT);
   assign bus.dut_sram_write_enable  = (state_q == S_WRITE);
   assign bus.dut_sram_write_address = addr_q;
   assign bus.dut_sram_write_data    = word_q;
   assign bus.busy                   = (state_q != S_IDLE);
   assign bus.done                   = (state_q == S_DONE);
   assign bus.wrap                   = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// ============================================================================
// tb_conv_result_packer : directed vector table plus randomized runs
// Rev 1.0
// ============================================================================
module tb_conv_result_packer;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic reset_b;
   always #5 clk = ~clk;

   conv_result_packer_if #(.ADDR_W(AW)) bus ();

   conv_result_packer #(.ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus.slave)
   );

   int         n_pass  = 0;
   int         n_total = 0;
   logic [27:0] wq[$];
   logic [27:0] eq[$];
   logic [3:0]  tiles[16];

   typedef struct {
      logic [11:0] base;
      int          n;
      logic [31:0] tv;
      bit          fl;
      int          nw;
      logic [27:0] w0;
      logic [27:0] w1;
      bit          wr;
   } vec_t;
   vec_t vecs[7];

   always @(negedge clk) begin
      if (bus.dut_sram_write_enable === 1'b1)
         wq.push_back({bus.dut_sram_write_address, bus.dut_sram_write_data});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: ceil(n/4) words, zero-padded, at consecutive addresses mod 4096
   task automatic build_exp(input logic [11:0] base, input int n, output bit w);
      logic [15:0] d;
      eq.delete();
      w = 1'b0;
      for (int i = 0; i * 4 < n; i++) begin
         d = '0;
         for (int j = 0; j < 4; j++)
            if (i * 4 + j < n) d[j*4 +: 4] = tiles[i*4+j];
         eq.push_back({base + 12'(i), d});
         if (base + 12'(i) == 12'hFFF) w = 1'b1;
      end
   endtask

   task automatic do_run(input logic [11:0] base, input int n, input bit fl,
                         input bit gaps, input bit exp_wrap);
      int waitc;
      wq.delete();
      bus.start     = 1'b1;
      bus.base_addr = base;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.base_addr = 12'($urandom);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
         waitc = 0;
         while (!bus.in_ready && waitc < 10) begin
            @(posedge clk); #1;
            waitc++;
         end
         if (!bus.in_ready) begin
            chk("ready_timeout", 32'(bus.in_ready), 1);
            break;
         end
         bus.in_valid = 1'b1;
         bus.in_tile  = tiles[k];
         bus.flush    = fl && (k == n - 1);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         bus.flush    = 1'b0;
         bus.in_tile  = 4'($urandom);
      end
      if (!(fl && n > 0)) begin
         bus.flush = 1'b1;
         @(posedge clk); #1;
         bus.flush = 1'b0;
      end
      waitc = 0;
      while (!bus.done && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("done_seen", 32'(bus.done), 1);
      if (n == 0) chk("done_latency", 32'(waitc), 0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(bus.done), 0);
      chk("busy_after", 32'(bus.busy), 0);
      chk("wrap", 32'(bus.wrap), 32'(exp_wrap));
      chk("nwrites", 32'(wq.size()), 32'(eq.size()));
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         chk("waddr", 32'(wq[i][27:16]), 32'(eq[i][27:16]));
         chk("wdata", 32'(wq[i][15:0]), 32'(eq[i][15:0]));
      end
   endtask

   initial begin
      bit w;
      int n;
      logic [11:0] b;

      vecs[0] = '{12'h010, 4, 32'h0000_4321, 1'b0, 1, {12'h010, 16'h4321}, 28'h0, 1'b0};
      vecs[1] = '{12'h100, 6, 32'h00FF_FFFF, 1'b0, 2, {12'h100, 16'hFFFF}, {12'h101, 16'h00FF}, 1'b0};
      vecs[2] = '{12'h055, 0, 32'h0000_0000, 1'b0, 0, 28'h0, 28'h0, 1'b0};
      vecs[3] = '{12'hFFF, 8, 32'h8765_4321, 1'b0, 2, {12'hFFF, 16'h4321}, {12'h000, 16'h8765}, 1'b1};
      vecs[4] = '{12'h200, 4, 32'h0000_DCBA, 1'b1, 1, {12'h200, 16'hDCBA}, 28'h0, 1'b0};
      vecs[5] = '{12'h300, 5, 32'h0005_4321, 1'b1, 2, {12'h300, 16'h4321}, {12'h301, 16'h0005}, 1'b0};
      vecs[6] = '{12'hFFF, 3, 32'h0000_0907, 1'b0, 1, {12'hFFF, 16'h0907}, 28'h0, 1'b1};

      reset_b       = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.in_valid  = 1'b0;
      bus.in_tile   = '0;
      bus.flush     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_wrap", 32'(bus.wrap), 0);
      chk("rst_en", 32'(bus.dut_sram_write_enable), 0);
      chk("rst_addr", 32'(bus.dut_sram_write_address), 0);
      chk("rst_data", 32'(bus.dut_sram_write_data), 0);
      reset_b = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         for (int k = 0; k < 8; k++) tiles[k] = vecs[v].tv[k*4 +: 4];
         eq.delete();
         if (vecs[v].nw > 0) eq.push_back(vecs[v].w0);
         if (vecs[v].nw > 1) eq.push_back(vecs[v].w1);
         do_run(vecs[v].base, vecs[v].n, vecs[v].fl, 1'b0, vecs[v].wr);
      end

      // Reset landing on the WRITE cycle, with a competing start
      wq.delete();
      bus.start     = 1'b1;
      bus.base_addr = 12'h020;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_tile  = 4'(k + 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("pre_rst_en", 32'(bus.dut_sram_write_enable), 1);
      chk("pre_rst_addr", 32'(bus.dut_sram_write_address), 32'h020);
      chk("pre_rst_data", 32'(bus.dut_sram_write_data), 32'h4321);
      reset_b       = 1'b1;
      bus.start     = 1'b1;
      bus.base_addr = 12'h0AA;
      @(posedge clk); #1;
      reset_b   = 1'b0;
      bus.start = 1'b0;
      chk("post_rst_en", 32'(bus.dut_sram_write_enable), 0);
      chk("post_rst_busy", 32'(bus.busy), 0);
      chk("post_rst_ready", 32'(bus.in_ready), 0);
      chk("post_rst_addr", 32'(bus.dut_sram_write_address), 0);
      chk("post_rst_data", 32'(bus.dut_sram_write_data), 0);
      @(posedge clk); #1;
      chk("rst_over_start", 32'(bus.busy), 0);
      chk("rst_one_write", 32'(wq.size()), 1);

      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(0, 11);
         b = ($urandom_range(0, 3) == 0) ? 12'(12'hFFD + 12'($urandom_range(0, 3)))
                                         : 12'($urandom);
         for (int k = 0; k < 16; k++) tiles[k] = 4'($urandom);
         build_exp(b, n, w);
         do_run(b, n, 1'($urandom_range(0, 1)), 1'b1, w);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/conv_result_packer.md
CONV_RESULT_PACKER -- requirements
Module: conv_result_packer

Interface
REQ-001 Parameter: ADDR_W, default 12, width of the SRAM word address.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_b  input  1  synchronous, active-high reset; clears state on the rising clk edge where reset_b=1.
REQ-004 start  input  1  one-cycle pulse in IDLE; loads base_addr and begins a packing run.
REQ-005 base_addr  input  ADDR_W  first SRAM word address of the run, sampled on start.
REQ-006 in_valid  input  1  upstream convolution stage presents a 2x2 result tile.
REQ-007 in_tile  input  4  result tile; bit0 top-left, bit1 top-right, bit2 lower-left, bit3 lower-right.
REQ-008 in_ready  output  1  packer accepts in_tile this cycle; transfer occurs when in_valid=1 and in_ready=1.
REQ-009 flush  input  1  end of run; write any partial word, then finish.
REQ-010 dut_sram_write_address  output  ADDR_W  SRAM write address.
REQ-011 dut_sram_write_data  output  16  packed word of four tiles.
REQ-012 dut_sram_write_enable  output  1  one-cycle SRAM write strobe.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a run completes.
REQ-015 wrap  output  1  sticky flag; address counter wrapped during the run.

Function
REQ-016 States: IDLE, COLLECT, WRITE, DONE; DONE always returns to IDLE on the next cycle.
REQ-017 IDLE: start=1 -> COLLECT; addr<=base_addr, tile count<=0, word<=0, wrap<=0. start is ignored outside IDLE.
REQ-018 COLLECT: in_ready=1; each accepted tile k (k=0..3) is stored at word[4k+3:4k]; count increments by 1.
REQ-019 The transfer that makes count=4 moves the block to WRITE on the next cycle; in_ready=0 in WRITE.
REQ-020 WRITE lasts exactly 1 cycle: dut_sram_write_enable=1; data=packed word; address=current addr.
REQ-021 After WRITE: addr<=addr+1 (mod 2^ADDR_W); count<=0; word<=0; next state is COLLECT, or DONE if a flush is pending.
REQ-022 Address wrap (all-ones -> 0) sets wrap=1, which holds until the next start or reset.
REQ-023 flush in COLLECT with count>0 (counted after any same-cycle transfer) -> WRITE; unused nibbles are written as 0; then DONE.
REQ-024 flush in COLLECT with count=0 -> DONE directly, with no SRAM write.
REQ-025 flush and an accepted tile in the same cycle: the tile is stored first, then the flush takes effect; if that tile fills the word, one WRITE is followed by DONE.
REQ-026 flush asserted during WRITE is latched as pending and honoured after that write.
REQ-027 DONE: done=1 for 1 cycle; busy=0 from the following cycle.
REQ-028 dut_sram_write_enable=0 in every state except WRITE.
REQ-029 dut_sram_write_data and dut_sram_write_address are registered; they are stable throughout WRITE.

Reset
REQ-030 On reset: state=IDLE; in_ready=0; busy=0; done=0; wrap=0; dut_sram_write_enable=0; dut_sram_write_address=0; dut_sram_write_data=0; count=0.
REQ-031 Reset during WRITE: dut_sram_write_enable=0 from the cycle after the reset edge; no further write occurs; the partial word is discarded.
REQ-032 Reset has priority over start, flush and in_valid in the same cycle.

Verification
REQ-033 start with base_addr=0x010, then tiles 0x1,0x2,0x3,0x4 back-to-back -> one write: addr 0x010, data 0x4321, enable high for exactly 1 cycle.
REQ-034 Six tiles 0xF, then flush -> writes 0xFFFF@base and 0x00FF@base+1, then done pulse, busy falls.
REQ-035 start then immediate flush with no tiles -> no write; done pulses 1 cycle after flush.
REQ-036 base_addr=0xFFF, eight tiles -> writes at 0xFFF then 0x000; wrap=1 after the second run of addressing.
REQ-037 Fourth tile and flush in the same cycle -> a single write then done; no extra padded write.
REQ-038 reset_b=1 asserted on the WRITE cycle -> enable low the next cycle; state IDLE; a later start works normally.
